// File: rtl/dmem_hs.sv
// dmem_hs -- word-organised data memory for the pipelined MIPS core.
//
// A request is accepted on the request channel, waits LAT cycles, and then
// accesses the array. The result is held on the response channel until the
// consumer takes it. Only one request is outstanding at a time.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_ready_o is high only in IDLE and is low while reset is
// asserted. resp_valid_o is high only in RESP. resp_rdata_o and resp_err_o
// hold steady until the cycle in which resp_ready_i is 1.
//
// Parameters:
//   ADDR_W  word-address bits (depth = 2**ADDR_W words)
//   LAT     wait cycles between accept and array access (0..15)
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (clears the RAM)
//   req_valid_i     request present
//   req_ready_o     block can accept a request
//   req_we_i        1 = store, 0 = load
//   req_addr_i      byte address
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_sext_i      loads: 1 = sign-extend, 0 = zero-extend
//   req_wdata_i     right-justified store data
//   req_pc_i        PC of the issuing instruction (trace only)
//   resp_valid_o    response present
//   resp_ready_i    consumer accepts the response
//   resp_rdata_o    extended load data (0 for stores and errors)
//   resp_err_o      misaligned, out-of-range or illegal-size request
//   state_o         FSM state (0 IDLE, 1 BUSY, 2 RESP) for debug
//
// Optional macro DMEM_TRACE_EN: prints one line per committed store.

module dmem_hs #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sext_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_pc_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  state_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap;
  logic        access;

  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] wdata_q;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [31:0] rd_word;
  logic        acc_err;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic        mem_we;

  // ---------------------------------------------------------------------
  // Request capture: inputs are only looked at on the accept edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
    end else if (cap) begin
      we_q    <= req_we_i;
      addr_q  <= req_addr_i;
      size_q  <= req_size_i;
      sext_q  <= req_sext_i;
      wdata_q <= req_wdata_i;
    end
  end

`ifdef DMEM_TRACE_EN
  logic [31:0] pc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else if (cap) begin
      pc_q <= req_pc_i;
    end
  end
`else
  // PC only feeds the trace; reduce it so the input is not left dangling.
  logic unused_pc;
  assign unused_pc = ^req_pc_i;
`endif

  // ---------------------------------------------------------------------
  // Access datapath (evaluated from the captured request)
  // ---------------------------------------------------------------------
  assign widx    = addr_q[ADDR_W+1:2];
  assign rd_word = mem_q[widx];

  always_comb begin
    acc_err = 1'b0;
    if ((addr_q >> (ADDR_W + 2)) != 32'd0) acc_err = 1'b1;
    case (size_q)
      2'b00:   ;
      2'b01:   if (addr_q[0]) acc_err = 1'b1;
      2'b10:   if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
      default: acc_err = 1'b1;
    endcase
  end

  // Load: pick the addressed lane(s) and extend.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = '0;
    h = '0;
    load_data = rd_word;
    case (addr_q[1:0])
      2'd0:    b = rd_word[7:0];
      2'd1:    b = rd_word[15:8];
      2'd2:    b = rd_word[23:16];
      default: b = rd_word[31:24];
    endcase
    h = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   load_data = sext_q ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   load_data = sext_q ? {{16{h[15]}}, h} : {16'd0, h};
      default: load_data = rd_word;
    endcase
  end

  // Store: replicate the data across lanes, then let the mask choose which
  // lanes take new data and which keep the old word.
  always_comb begin
    lane_mask = 4'b1111;
    lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        lane_mask = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lane_mask[i] ? lane_data[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  assign mem_we = access && we_q && !acc_err;

  // Reset wipes every word; reset also wins over a pending write, so a
  // store interrupted by reset never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[widx] <= merged;
`ifdef DMEM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, merged);
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cap     = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          cap     = 1'b1;
          cnt_d   = 4'(LAT);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          err_d   = acc_err;
          rdata_d = (we_q || acc_err) ? 32'd0 : load_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o  = (state_q == IDLE) && !reset;
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dmem_hs.sv
module tb_dmem_hs;

  logic        clk;
  logic        reset;
  logic        sel;          // 0 -> LAT=2 instance, 1 -> LAT=0 instance
  logic        req_valid;
  logic        resp_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;

  logic        a_req_ready, a_resp_valid, a_err;
  logic [31:0] a_rdata;
  logic [1:0]  a_state;
  logic        b_req_ready, b_resp_valid, b_err;
  logic [31:0] b_rdata;
  logic [1:0]  b_state;

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  state;

  int n_cmp;
  int n_bad;

  dmem_hs #(.ADDR_W(10), .LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid & ~sel), .req_ready_o(a_req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_sext_i(req_sext), .req_wdata_i(req_wdata), .req_pc_i(req_pc),
    .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready & ~sel),
    .resp_rdata_o(a_rdata), .resp_err_o(a_err), .state_o(a_state)
  );

  dmem_hs #(.ADDR_W(10), .LAT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid & sel), .req_ready_o(b_req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_sext_i(req_sext), .req_wdata_i(req_wdata), .req_pc_i(req_pc),
    .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready & sel),
    .resp_rdata_o(b_rdata), .resp_err_o(b_err), .state_o(b_state)
  );

  assign req_ready  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign resp_rdata = sel ? b_rdata      : a_rdata;
  assign resp_err   = sel ? b_err        : a_err;
  assign state      = sel ? b_state      : a_state;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request and hold it until the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sext, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_sext  = sext;
    req_wdata = wdata;
    req_pc    = 32'h0040_0000 + addr;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;   // garbage after accept must not matter
    req_addr  = 32'h0000_0FFC;
  endtask

  // Count edges after the accept edge until resp_valid appears.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 50) check_eq("resp_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic sext, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    issue(we, addr, size, sext, wdata);
    wait_resp(lat);
    check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
    check_eq({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    check_eq({tag, "_lat"}, lat, exp_lat);
    consume();
  endtask

  task automatic cases_1_to_3(input int l);
    run("sw10",   1'b1, 32'h10, 2'b10, 1'b0, 32'h1234_5678, 32'h0,          1'b0, l + 1);
    run("lw10a",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         32'h1234_5678,  1'b0, l + 1);
    run("sb11",   1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_00AB, 32'h0,          1'b0, l + 1);
    run("lw10b",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         32'h1234_AB78,  1'b0, l + 1);
    run("lb11s",  1'b0, 32'h11, 2'b00, 1'b1, 32'h0,         32'hFFFF_FFAB,  1'b0, l + 1);
    run("lbu11",  1'b0, 32'h11, 2'b00, 1'b0, 32'h0,         32'h0000_00AB,  1'b0, l + 1);
    run("sh12",   1'b1, 32'h12, 2'b01, 1'b0, 32'h0000_8001, 32'h0,          1'b0, l + 1);
    run("lw10c",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         32'h8001_AB78,  1'b0, l + 1);
    run("lh12s",  1'b0, 32'h12, 2'b01, 1'b1, 32'h0,         32'hFFFF_8001,  1'b0, l + 1);
    run("lhu12",  1'b0, 32'h12, 2'b01, 1'b0, 32'h0,         32'h0000_8001,  1'b0, l + 1);
  endtask

  initial begin
    int lat;
    logic seen;
    n_cmp = 0;
    n_bad = 0;
    sel = 1'b0;
    reset = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_size = '0;
    req_sext = 1'b0;
    req_wdata = '0;
    req_pc = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", {31'd0, resp_err}, 32'd0);
    check_eq("rst_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // cases 1-3, LAT=2
    cases_1_to_3(2);

    // case 4: errors
    run("lw13_err",  1'b0, 32'h13,   2'b10, 1'b0, 32'h0,          32'h0, 1'b1, 3);
    run("sw1000_err",1'b1, 32'h1000, 2'b10, 1'b0, 32'h5555_5555,  32'h0, 1'b1, 3);
    run("lh11_err",  1'b0, 32'h11,   2'b01, 1'b0, 32'h0,          32'h0, 1'b1, 3);
    run("sz3_err",   1'b1, 32'h10,   2'b11, 1'b0, 32'h0,          32'h0, 1'b1, 3);
    run("lw10d",     1'b0, 32'h10,   2'b10, 1'b0, 32'h0,   32'h8001_AB78, 1'b0, 3);

    // case 5: back-pressure on the response
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    wait_resp(lat);
    check_eq("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2);
      req_addr  = 32'h20;
      req_we    = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("bp_rdata", resp_rdata, 32'h8001_AB78);
      check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("bp_release_state", {30'd0, state}, 32'd0);
    check_eq("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("bp_pulse_ignored", {30'd0, state}, 32'd0);

    // case 6: reset during BUSY of a store
    issue(1'b1, 32'h20, 2'b10, 1'b0, 32'hDEAD_BEEF);
    check_eq("busy_state", {30'd0, state}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("busy_rst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("busy_rst_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check_eq("busy_rst_no_resp", {31'd0, seen}, 32'd0);
    run("lw20_after_rst", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3);
    run("lw10_after_rst", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3);

    // cases 1-3 again on the LAT=0 instance
    sel = 1'b1;
    cases_1_to_3(0);
    run("lat0_err", 1'b0, 32'h2, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
